// File: rtl/enclave_pkg.sv
// Shared types for the encrypt sequencer and datapath: sequencer FSM
// states, the chunk-count derivation and the default operand lane array.
package enclave_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } sched_state_t;

  localparam int ENC_PARALLEL = 2;
  localparam int ENC_CT_W     = 32;

  typedef logic [ENC_PARALLEL-1:0][ENC_CT_W-1:0] lanes_t;

  // Beats per row; BIG_N is required to be a multiple of PARALLEL.
  function automatic int calc_chunks(input int big_n, input int parallel);
    return big_n / parallel;
  endfunction

endpackage

// File: rtl/encrypt_res_fifo.sv
// Two-entry result FIFO of {ciphertext, row}. Push while full is only
// accepted when a pop happens in the same cycle.
module encrypt_res_fifo #(
  parameter int DW = 32,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [RW-1:0] push_row,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [RW-1:0] row,
  output logic [1:0]    count
);

  logic [1:0][DW-1:0] d_mem;
  logic [1:0][RW-1:0] r_mem;
  logic               wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign data    = valid ? d_mem[rd_ptr] : '0;
  assign row     = valid ? r_mem[rd_ptr] : '0;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_mem  <= '0;
      r_mem  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        d_mem[wr_ptr] <= push_data;
        r_mem[wr_ptr] <= push_row;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/encrypt_sched.sv
// Sequencer for the encrypt datapath: walks operand beats row by row,
// forwards them one cycle later to the datapath and captures each row's
// ciphertext into a 2-entry result FIFO. Row issue is credit-gated so the
// FIFO can never overflow.
// Optional: define ENCRYPT_SCHED_PERF_EN to add perf_cycles/perf_stalls.
module encrypt_sched
  import enclave_pkg::*;
#(
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int DIMENSION        = 3,
  parameter int DIM_WIDTH        = 2,
  parameter int BIG_N            = 4,
  parameter int PARALLEL         = 2,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     job_done,
  output logic                                     mem_rd,
  output logic [ADDR_WIDTH-1:0]                    mem_addr,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] mem_op1,
  input  logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] mem_op2,
  output logic                                     enc_en,
  output logic                                     enc_done,
  output logic [DIM_WIDTH:0]                       enc_row,
  output logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] enc_op1,
  output logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0] enc_op2,
  input  logic [CIPHERTEXT_WIDTH-1:0]              enc_ciphertext,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]              res_data,
  output logic [DIM_WIDTH:0]                       res_row
`ifdef ENCRYPT_SCHED_PERF_EN
  ,
  output logic [31:0]                              perf_cycles,
  output logic [31:0]                              perf_stalls
`endif
);

  localparam int CHUNKS = calc_chunks(BIG_N, PARALLEL);
  localparam int CHW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int RW     = DIM_WIDTH + 1;

  sched_state_t   state, state_nx;
  logic [RW-1:0]  row;
  logic [CHW-1:0] chunk;
  logic [1:0]     pending;     // rows started but not yet pushed
  logic [1:0]     fifo_count;
  logic           flush_cnt;
  logic           first_beat, last_chunk, last_row, credit_ok, pop;
  logic           lc_q, cap_q;
  logic [RW-1:0]  cap_row;
  logic [2:0]     used, avail;

  assign busy       = (state != S_IDLE);
  assign first_beat = (chunk == '0);
  assign last_chunk = (chunk == CHW'(CHUNKS - 1));
  assign last_row   = (row == RW'(DIMENSION - 1));
  assign pop        = res_valid & res_ready;
  assign mem_addr   = ADDR_WIDTH'(row) * ADDR_WIDTH'(CHUNKS) + ADDR_WIDTH'(chunk);
  assign enc_op1    = enc_en ? mem_op1 : '0;
  assign enc_op2    = enc_en ? mem_op2 : '0;

  // A new row needs one free slot; a pop in this cycle already frees one.
  assign used      = {1'b0, fifo_count} + {1'b0, pending};
  assign avail     = 3'd2 + {2'b0, pop};
  assign credit_ok = (used < avail);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, read strobe and completion pulse.
  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    job_done = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (!first_beat || credit_ok) begin
        mem_rd = 1'b1;
        if (last_row && last_chunk) state_nx = S_FLUSH;
      end
      S_FLUSH: if (flush_cnt) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_count == 2'd0) begin
        job_done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Row/chunk walk, flush timer and committed-row tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      chunk     <= '0;
      flush_cnt <= 1'b0;
      pending   <= 2'd0;
    end else begin
      if (state == S_IDLE) begin
        row   <= '0;
        chunk <= '0;
      end else if (mem_rd) begin
        if (last_chunk) begin
          chunk <= '0;
          row   <= row + RW'(1);
        end else begin
          chunk <= chunk + CHW'(1);
        end
      end
      flush_cnt <= (state == S_FLUSH) & ~flush_cnt;
      case ({mem_rd & first_beat, cap_q})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: ;
      endcase
    end
  end

  // Operand stage to the datapath, then the capture strobe one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_en   <= 1'b0;
      enc_done <= 1'b0;
      enc_row  <= '0;
      lc_q     <= 1'b0;
      cap_q    <= 1'b0;
      cap_row  <= '0;
    end else begin
      enc_en   <= mem_rd;
      enc_done <= mem_rd & last_row & last_chunk;
      enc_row  <= mem_rd ? row : '0;
      lc_q     <= mem_rd & last_chunk;
      cap_q    <= lc_q;
      cap_row  <= enc_row;
    end
  end

  encrypt_res_fifo #(.DW(CIPHERTEXT_WIDTH), .RW(RW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_q),
    .push_data (enc_ciphertext),
    .push_row  (cap_row),
    .pop       (res_ready),
    .valid     (res_valid),
    .data      (res_data),
    .row       (res_row),
    .count     (fifo_count)
  );

`ifdef ENCRYPT_SCHED_PERF_EN
  // Saturating job counters, cleared when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state == S_ISSUE && !mem_rd && perf_stalls != '1)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/encrypt_sched.md
Name: encrypt_sched

Overview:
- Sequencer for the `encrypt` datapath. Reads PARALLEL-wide operand beats from the public-key/randomness operand memories, row by row and chunk by chunk.
- Drives the datapath's en/row/done/op1/op2 inputs and captures each row's ciphertext into a 2-entry result FIFO, exposed as a valid/ready stream.
- Sits between the top-level command interface and `encrypt`.

Parameters:
- CIPHERTEXT_WIDTH, 32, width of each operand lane and of the ciphertext word
- DIMENSION, 3, number of ciphertext rows per job
- DIM_WIDTH, 2, row index width; row ports are DIM_WIDTH+1 bits, matching `encrypt`
- BIG_N, 4, operand columns per row; must be a multiple of PARALLEL
- PARALLEL, 2, lanes per beat
- ADDR_WIDTH, 8, operand memory address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only when busy=0
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse when the last result has been accepted downstream
- mem_rd  out  1  operand memory read strobe
- mem_addr  out  ADDR_WIDTH  beat address = row*CHUNKS + chunk
- mem_op1  in  PARALLEL x CIPHERTEXT_WIDTH  op1 lanes, valid 1 cycle after mem_rd
- mem_op2  in  PARALLEL x CIPHERTEXT_WIDTH  op2 lanes, valid 1 cycle after mem_rd
- enc_en  out  1  datapath enable
- enc_done  out  1  datapath done
- enc_row  out  DIM_WIDTH+1  datapath row index
- enc_op1  out  PARALLEL x CIPHERTEXT_WIDTH  to datapath op1
- enc_op2  out  PARALLEL x CIPHERTEXT_WIDTH  to datapath op2
- enc_ciphertext  in  CIPHERTEXT_WIDTH  datapath result
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  downstream accept
- res_data  out  CIPHERTEXT_WIDTH  ciphertext word
- res_row  out  DIM_WIDTH+1  row of res_data

Behaviour:
- CHUNKS = BIG_N/PARALLEL.
- Reset (async, rst=1): every output 0, FSM IDLE, FIFO empty, all counters 0. Reset mid-job abandons the job with no job_done.
- FSM states: IDLE, ISSUE, FLUSH, DRAIN.
  - IDLE: start=1 -> ISSUE, busy=1 from the next cycle. Row/chunk counters cleared.
  - ISSUE: mem_rd=1 with mem_addr = row*CHUNKS+chunk on every cycle not stalled. Chunk wraps at CHUNKS-1 and increments row. After issuing (DIMENSION-1, CHUNKS-1) -> FLUSH.
  - FLUSH: waits for the in-flight beat and capture to complete (2 cycles), then -> DRAIN.
  - DRAIN: waits until the FIFO is empty, pulses job_done for 1 cycle, then -> IDLE with busy=0.
- Operand pipeline (1 stage):
  - Cycle after mem_rd: enc_en=1, enc_op1/2 = mem_op1/2, and enc_row = the issued row (registered alongside the address).
  - enc_en=0 and enc_op=0 on bubbles.
  - enc_done=1 together with the last beat of the last row.
- Capture: the cycle after the last beat of row r is presented, the FIFO pushes {enc_ciphertext, r}. That is row-result latency = 2 cycles after the last mem_rd of the row.
- Credits: credits = free FIFO entries minus rows already committed but not yet pushed. The first beat of a row is issued only if credits >= 1; otherwise mem_rd=0 (stall) and the counters hold. Beats inside a row never stall. As a result, the FIFO never overflows.
- FIFO pop: res_valid && res_ready. Simultaneous push and pop when full is legal, and count stays at 2.
- start while busy=1: ignored.
- res_ready held low: issue stalls at the next row boundary and nothing is lost.

Optional Feature:
- ENCRYPT_SCHED_PERF_EN defined:
  - Adds outputs perf_cycles[31:0] (cycles with busy=1) and perf_stalls[31:0] (ISSUE cycles with mem_rd=0).
  - Both clear on accepted start, hold after job_done, and saturate at all-ones.
- Undefined: the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Shared package `enclave_pkg`: the FSM state enum, CHUNKS derivation, and lane-array typedef (PARALLEL x CIPHERTEXT_WIDTH) shared with `encrypt`.
- Sub-module `encrypt_res_fifo`: 2-entry synchronous FIFO of {data,row} with count output, used for credit computation.

Test Plan:
- Basic job (DIMENSION=3, BIG_N=4, PARALLEL=2, res_ready=1): start pulse -> mem_addr 0,1,2,3,4,5 on consecutive cycles; enc_row sequence 0,0,1,1,2,2; enc_done on the 6th beat; 3 results rows 0,1,2; job_done 1 cycle after the last pop.
- Datapath pass-through: memory returns op1={25,5}, op2={13,5}, then {2,0},{5,0}, with a model encrypt summing to 55 -> res_data=55, res_row=0.
- Backpressure: res_ready=0 throughout -> exactly 2 results queued, mem_rd stalls before row 2's first beat (addr 4). Raising res_ready -> issue resumes, all 3 rows delivered in order, no loss or duplication.
- Pop/push collision: FIFO full, res_ready=1 on the capture cycle -> count stays 2 and data order is preserved.
- Reset mid-job: assert rst during row 1 -> all outputs 0 the same cycle, no job_done. A new start afterwards completes normally from addr 0.
- Ignored start: start pulses while busy -> no counter restart, single job_done. With ENCRYPT_SCHED_PERF_EN: basic job -> perf_stalls=0, perf_cycles = total busy cycles.
